dm_cache_rd: RTL and testbench

Parametrised direct-mapped read cache with a blocking miss-refill state machine. It sits between a word-wide requester and a block-wide backing memory. It services hits from local tag/data storage and fetches whole lines on a miss over a valid/ready handshake. It also supports a whole-cache flush and keeps saturating hit/miss statistics.

---
 rtl/dm_cache_pkg.sv | 24 ++
 rtl/dm_cache_array.sv | 33 +++
 rtl/dm_cache_rd.sv | 139 +++++++++++++
 tb/tb_dm_cache_rd.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_cache_pkg.sv
// Shared types and derived-width helpers for the direct-mapped read cache.
package dm_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_RESP
  } state_t;

  function automatic int offset_w(input int words_per_block);
    return $clog2(words_per_block);
  endfunction

  function automatic int tag_w(input int addr_w, input int index_w, input int words_per_block);
    return addr_w - index_w - offset_w(words_per_block);
  endfunction

  function automatic int line_w(input int words_per_block, input int word_w);
    return words_per_block * word_w;
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Tag and line storage: one synchronous write port, one asynchronous read port by index.
module dm_cache_array #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 3,
  parameter int LINE_W  = 128
) (
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] widx,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [LINE_W-1:0]  wline,
  input  logic [INDEX_W-1:0] ridx,
  output logic [TAG_W-1:0]   rtag,
  output logic [LINE_W-1:0]  rline
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [LINE_W-1:0] data_mem [DEPTH];

  // Contents are qualified by the controller's valid bits, so no reset here.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= wline;
    end
  end

  assign rtag  = tag_mem[ridx];
  assign rline = data_mem[ridx];

endmodule

// File: rtl/dm_cache_rd.sv
// Direct-mapped read cache with blocking miss refill, whole-cache flush and saturating stats.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid holds its payload until then.
module dm_cache_rd
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W          = 15,
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int INDEX_W         = 10,
  parameter int CNT_W           = 32
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             req_valid,
  output logic                                             req_ready,
  input  logic [ADDR_W-1:0]                                req_addr,
  output logic                                             rsp_valid,
  output logic [WORD_W-1:0]                                rsp_data,
  output logic                                             rsp_hit,
  input  logic                                             flush,
  output logic                                             mem_req_valid,
  input  logic                                             mem_req_ready,
  output logic [ADDR_W-offset_w(WORDS_PER_BLOCK)-1:0]      mem_req_addr,
  input  logic                                             mem_rsp_valid,
  input  logic [line_w(WORDS_PER_BLOCK, WORD_W)-1:0]       mem_rsp_data,
  output logic [CNT_W-1:0]                                 hit_cnt,
  output logic [CNT_W-1:0]                                 miss_cnt,
  output state_t                                           dbg_state
);

  localparam int OFFSET_W = offset_w(WORDS_PER_BLOCK);
  localparam int TAG_W    = tag_w(ADDR_W, INDEX_W, WORDS_PER_BLOCK);
  localparam int LINE_W   = line_w(WORDS_PER_BLOCK, WORD_W);
  localparam int LINES    = 1 << INDEX_W;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [OFFSET_W-1:0]   off;
  logic [INDEX_W-1:0]    idx;
  logic [TAG_W-1:0]      tag;
  logic [LINES-1:0]      valid_q;
  logic                  flush_pending_q;
  logic                  flush_now;
  logic                  hit;
  logic                  refill;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_W-1:0]     rd_line;
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] rd_words;
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] mem_words;
  logic [WORD_W-1:0]     rsp_data_q;
  logic                  rsp_hit_q;
  logic [CNT_W-1:0]      hit_cnt_q, miss_cnt_q;

  assign {tag, idx, off} = addr_q;
  assign flush_now = flush | flush_pending_q;
  assign hit       = valid_q[idx] && (rd_tag == tag);
  assign refill    = (state_q == ST_MEM_WAIT) && mem_rsp_valid;
  assign rd_words  = rd_line;
  assign mem_words = mem_rsp_data;

  dm_cache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_array (
    .clk   (clk),
    .we    (refill),
    .widx  (idx),
    .wtag  (tag),
    .wline (mem_rsp_data),
    .ridx  (idx),
    .rtag  (rd_tag),
    .rline (rd_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (!flush_now && req_valid) state_d = ST_LOOKUP;
      ST_LOOKUP:   state_d = hit ? ST_RESP : ST_MEM_REQ;
      ST_MEM_REQ:  if (mem_req_ready) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (mem_rsp_valid) state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      rsp_data_q      <= '0;
      rsp_hit_q       <= 1'b0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      if (req_valid && req_ready) addr_q <= req_addr;

      // A flush seen mid-access is deferred to the next IDLE cycle so the refill still lands.
      if (state_q == ST_IDLE)  flush_pending_q <= 1'b0;
      else if (flush)          flush_pending_q <= 1'b1;

      if ((state_q == ST_IDLE) && flush_now) valid_q <= '0;
      else if (refill)                       valid_q[idx] <= 1'b1;

      if (state_q == ST_LOOKUP) begin
        if (hit) begin
          rsp_data_q <= rd_words[off];
          rsp_hit_q  <= 1'b1;
          if (!(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end else begin
          if (!(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
      end

      if (refill) begin
        rsp_data_q <= mem_words[off];
        rsp_hit_q  <= 1'b0;
      end
    end
  end

  assign req_ready     = (state_q == ST_IDLE) && !flush_now;
  assign rsp_valid     = (state_q == ST_RESP);
  assign mem_req_valid = (state_q == ST_MEM_REQ);
  assign mem_req_addr  = addr_q[ADDR_W-1:OFFSET_W];
  assign rsp_data      = rsp_data_q;
  assign rsp_hit       = rsp_hit_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dm_cache_rd.sv
// Directed bench for dm_cache_rd: refill, hit, eviction, stall, flush, mid-miss reset, saturation.
module tb_dm_cache_rd;
  import dm_cache_pkg::*;

  localparam int ADDR_W  = 15;
  localparam int WORD_W  = 32;
  localparam int WPB     = 4;
  localparam int INDEX_W = 10;
  localparam int CNT_W   = 3;
  localparam int LINE_W  = 128;
  localparam int LADDR_W = 13;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic               rsp_valid;
  logic [WORD_W-1:0]  rsp_data;
  logic               rsp_hit;
  logic               flush;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [LADDR_W-1:0] mem_req_addr;
  logic               mem_rsp_valid;
  logic [LINE_W-1:0]  mem_rsp_data;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;
  state_t             dbg_state;

  int checks = 0;
  int errors = 0;
  int lat;

  logic [LINE_W-1:0] line_a = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111};
  logic [LINE_W-1:0] line_b = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
  logic [LINE_W-1:0] line_c = {32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000};

  dm_cache_rd #(
    .ADDR_W          (ADDR_W),
    .WORD_W          (WORD_W),
    .WORDS_PER_BLOCK (WPB),
    .INDEX_W         (INDEX_W),
    .CNT_W           (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_hit       (rsp_hit),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Driver tasks: all start and end just after a falling edge.
  task automatic send_req(input logic [ADDR_W-1:0] addr);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept addr %0h got req_ready %0b exp 1", addr, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_mem_req(output int l);
    l = 1;
    while (!mem_req_valid && l < 30) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic mem_handshake(input int hold, input logic [LADDR_W-1:0] exp_addr);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d got mrv=%0b addr=%0h rr=%0b rv=%0b exp 1 %0h 0 0",
                 i, mem_req_valid, mem_req_addr, req_ready, rsp_valid, exp_addr);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
  endtask

  task automatic mem_refill(input logic [LINE_W-1:0] line);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1)     begin errors++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0)     begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0)     begin errors++; $display("FAIL reset_rsp_data got %0h exp 0", rsp_data); end
    checks++; if (rsp_hit !== 1'b0)       begin errors++; $display("FAIL reset_rsp_hit got %0b exp 0", rsp_hit); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got %0b exp 0", mem_req_valid); end
    checks++; if (mem_req_addr !== 13'h0) begin errors++; $display("FAIL reset_mem_req_addr got %0h exp 0", mem_req_addr); end
    checks++; if (hit_cnt !== 3'd0)       begin errors++; $display("FAIL reset_hit_cnt got %0d exp 0", hit_cnt); end
    checks++; if (miss_cnt !== 3'd0)      begin errors++; $display("FAIL reset_miss_cnt got %0d exp 0", miss_cnt); end
    checks++; if (dbg_state !== ST_IDLE)  begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_miss_refill();
    send_req(15'h0005);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL miss_early_mrv got %0b exp 0", mem_req_valid); end
    wait_mem_req(lat);
    checks++; if (lat !== 2)               begin errors++; $display("FAIL miss_mrv_latency got %0d exp 2", lat); end
    checks++; if (mem_req_addr !== 13'h001) begin errors++; $display("FAIL miss_addr got %0h exp 001", mem_req_addr); end
    checks++; if (miss_cnt !== 3'd1)       begin errors++; $display("FAIL miss_cnt1 got %0d exp 1", miss_cnt); end
    mem_handshake(0, 13'h001);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL miss_mrv_drop got %0b exp 0", mem_req_valid); end
    mem_refill(line_a);
    checks++; if (rsp_valid !== 1'b1)         begin errors++; $display("FAIL miss_rsp_valid got %0b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 32'hDEADBEEF)  begin errors++; $display("FAIL miss_rsp_data got %0h exp deadbeef", rsp_data); end
    checks++; if (rsp_hit !== 1'b0)           begin errors++; $display("FAIL miss_rsp_hit got %0b exp 0", rsp_hit); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL miss_rsp_pulse got rv=%0b rr=%0b exp 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_hit();
    send_req(15'h0006);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hit_early_rsp got %0b exp 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1)        begin errors++; $display("FAIL hit_rsp_valid got %0b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 32'h33333333) begin errors++; $display("FAIL hit_rsp_data got %0h exp 33333333", rsp_data); end
    checks++; if (rsp_hit !== 1'b1)          begin errors++; $display("FAIL hit_rsp_hit got %0b exp 1", rsp_hit); end
    checks++; if (hit_cnt !== 3'd1)          begin errors++; $display("FAIL hit_cnt1 got %0d exp 1", hit_cnt); end
    checks++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL hit_quiet got mrv=%0b rr=%0b exp 0 0", mem_req_valid, req_ready); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL hit_done got rv=%0b rr=%0b exp 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_evict_stall();
    send_req(15'h1005);
    wait_mem_req(lat);
    checks++; if (lat !== 2 || mem_req_addr !== 13'h401) begin errors++; $display("FAIL evict_req got lat=%0d addr=%0h exp 2 401", lat, mem_req_addr); end
    mem_handshake(5, 13'h401);
    mem_refill(line_b);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE0001 || rsp_hit !== 1'b0) begin errors++; $display("FAIL evict_rsp got rv=%0b data=%0h hit=%0b exp 1 cafe0001 0", rsp_valid, rsp_data, rsp_hit); end
    @(negedge clk);
    checks++; if (miss_cnt !== 3'd2) begin errors++; $display("FAIL evict_miss_cnt got %0d exp 2", miss_cnt); end
    send_req(15'h0005);
    wait_mem_req(lat);
    checks++; if (lat !== 2 || mem_req_addr !== 13'h001) begin errors++; $display("FAIL evicted_remiss got lat=%0d addr=%0h exp 2 001", lat, mem_req_addr); end
    mem_handshake(0, 13'h001);
    mem_refill(line_a);
    checks++; if (rsp_data !== 32'hDEADBEEF || rsp_hit !== 1'b0) begin errors++; $display("FAIL evicted_rsp got data=%0h hit=%0b exp deadbeef 0", rsp_data, rsp_hit); end
    @(negedge clk);
    checks++; if (miss_cnt !== 3'd3) begin errors++; $display("FAIL evicted_miss_cnt got %0d exp 3", miss_cnt); end
  endtask

  task automatic test_flush_inflight();
    send_req(15'h0009);
    wait_mem_req(lat);
    checks++; if (lat !== 2 || mem_req_addr !== 13'h002) begin errors++; $display("FAIL fl_req got lat=%0d addr=%0h exp 2 002", lat, mem_req_addr); end
    mem_handshake(0, 13'h002);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_wait_rsp got %0b exp 0", rsp_valid); end
    mem_refill(line_c);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h5A5A0001) begin errors++; $display("FAIL fl_rsp got rv=%0b data=%0h exp 1 5a5a0001", rsp_valid, rsp_data); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fl_pending_cycle got req_ready %0b exp 0", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fl_after_cycle got req_ready %0b exp 1", req_ready); end
    send_req(15'h0009);
    wait_mem_req(lat);
    checks++; if (lat !== 2 || mem_req_addr !== 13'h002) begin errors++; $display("FAIL fl_remiss got lat=%0d addr=%0h exp 2 002", lat, mem_req_addr); end
    mem_handshake(0, 13'h002);
    mem_refill(line_c);
    @(negedge clk);
    checks++; if (miss_cnt !== 3'd5 || hit_cnt !== 3'd1) begin errors++; $display("FAIL fl_counts got miss=%0d hit=%0d exp 5 1", miss_cnt, hit_cnt); end
  endtask

  task automatic test_flush_vs_req();
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 15'h0009;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fvr_ready got %0b exp 0", req_ready); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (dbg_state !== ST_IDLE || req_ready !== 1'b1) begin errors++; $display("FAIL fvr_blocked got state=%0d rr=%0b exp %0d 1", dbg_state, req_ready, ST_IDLE); end
    @(negedge clk);
    req_valid = 1'b0;
    wait_mem_req(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL fvr_flushed_miss got lat %0d exp 2", lat); end
    mem_handshake(0, 13'h002);
    mem_refill(line_c);
    @(negedge clk);
    checks++; if (miss_cnt !== 3'd6 || hit_cnt !== 3'd1) begin errors++; $display("FAIL fvr_counts got miss=%0d hit=%0d exp 6 1", miss_cnt, hit_cnt); end
  endtask

  task automatic test_reset_mid_miss();
    send_req(15'h000D);
    wait_mem_req(lat);
    mem_handshake(0, 13'h003);
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_async got mrv=%0b rr=%0b rv=%0b exp 0 1 0", mem_req_valid, req_ready, rsp_valid); end
    checks++; if (hit_cnt !== 3'd0 || miss_cnt !== 3'd0 || rsp_data !== 32'h0) begin errors++; $display("FAIL rst_regs got hit=%0d miss=%0d data=%0h exp 0 0 0", hit_cnt, miss_cnt, rsp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_refill(line_c);
    checks++; if (rsp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_stale_refill got rv=%0b state=%0d exp 0 %0d", rsp_valid, dbg_state, ST_IDLE); end
    send_req(15'h0009);
    wait_mem_req(lat);
    checks++; if (lat !== 2 || mem_req_addr !== 13'h002) begin errors++; $display("FAIL rst_remiss got lat=%0d addr=%0h exp 2 002", lat, mem_req_addr); end
    mem_handshake(0, 13'h002);
    mem_refill(line_c);
    checks++; if (rsp_data !== 32'h5A5A0001 || rsp_hit !== 1'b0) begin errors++; $display("FAIL rst_refill_rsp got data=%0h hit=%0b exp 5a5a0001 0", rsp_data, rsp_hit); end
    @(negedge clk);
    checks++; if (miss_cnt !== 3'd1) begin errors++; $display("FAIL rst_miss_cnt got %0d exp 1", miss_cnt); end
  endtask

  task automatic test_back_to_back_saturate();
    for (int i = 0; i < 8; i++) begin
      send_req(15'h000B);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_data !== 32'h5A5A0003) begin errors++; $display("FAIL b2b_hit%0d got rv=%0b hit=%0b data=%0h exp 1 1 5a5a0003", i, rsp_valid, rsp_hit, rsp_data); end
      @(negedge clk);
    end
    checks++; if (hit_cnt !== 3'd7)  begin errors++; $display("FAIL sat_hit_cnt got %0d exp 7", hit_cnt); end
    checks++; if (miss_cnt !== 3'd1) begin errors++; $display("FAIL sat_miss_cnt got %0d exp 1", miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_hit();
    test_evict_stall();
    test_flush_inflight();
    test_flush_vs_req();
    test_reset_mid_miss();
    test_back_to_back_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
